xbar_port_sender: RTL and testbench
===================================

Name: xbar_port_sender

Overview:
- Input-side initiator for the multicast crossbar.
- Buffers flits from an upstream source in a small FIFO and presents the head flit's data and destination bitmask to one crossbar input.
- Collects per-output acks over one or more cycles, re-requesting only the destinations not yet served, and retires the flit once every destination has acked.
- One instance sits in front of each crossbar input port.

Parameters:
- PORTS, 2, number of crossbar outputs; width of the destination mask and ack vector.
- WIDTH, 8, flit data width in bits.
- DEPTH, 4, FIFO depth in flits; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream flit valid.
- in_ready  output  1  FIFO can accept a flit; equals not full; registered-state only, no combinational path from ack_i.
- in_data  input  WIDTH  upstream flit payload.
- in_dest  input  PORTS  upstream destination bitmask; bit j means deliver to output j.
- xb_data  output  WIDTH  head flit payload to the crossbar; 0 when idle.
- xb_dest  output  PORTS  pending destination mask to the crossbar; 0 when idle.
- ack_i  input  PORTS  per-output grant from the crossbar for this input, same cycle as xb_dest.
- busy  output  1  a flit is being presented, i.e. xb_dest != 0.

Behaviour:
- Reset, asynchronous while rst=1:
  - FIFO empty; pointers and count 0.
  - pending mask 0; state IDLE.
  - in_ready=0 while rst is high, 1 on the first cycle after release.
  - xb_data=0, xb_dest=0, busy=0.
  - Any partially delivered flit is discarded.
- Push: an in_valid && in_ready handshake writes {in_data, in_dest} at the write pointer. The write pointer wraps modulo DEPTH.
- Zero-mask flit (in_dest=0): accepted and written, then popped on its first cycle at the head without ever being presented (xb_dest stays 0). It costs one cycle.
- FSM:
  - IDLE:
    - When the FIFO is non-empty, load pending from the head's dest and go to SEND.
    - Both happen on the same edge that the flit becomes head, so xb_dest is asserted no earlier than the cycle after the push.
  - SEND:
    - xb_data is the head payload; xb_dest is the pending mask.
    - Each edge: pending_next = pending & ~ack_i. Ack bits outside pending are ignored.
    - If pending_next == 0, pop the head.
      - If the FIFO still holds another flit, load pending from that next flit's dest and stay in SEND. There is no bubble between flits.
      - Otherwise go to IDLE.
- Latency: minimum push-to-presentation is 1 cycle. A fully acked flit retires in the same cycle it is presented.
- Partial multicast: xb_data stays stable until the flit retires. xb_dest shrinks monotonically.
- Full FIFO: in_ready=0. A pop in the same cycle frees the slot for the next cycle only; full-push-and-pop in one cycle is not supported.
- Empty with in_valid: there is no bypass; the flit goes through the FIFO.
- Simultaneous push and pop: both proceed; count is unchanged.
- Ordering: flits retire strictly in FIFO order. A later flit never overtakes an unfinished multicast.

Optional Feature:
- Macro: XBAR_SENDER_STATS_EN.
- Enabled:
  - Adds output stall_cnt [31:0], which increments each SEND cycle where pending_next != 0.
  - Adds output flit_cnt [31:0], which increments on each retire, including zero-mask retires.
  - Both counters are reset to 0 by rst and saturate at all-ones.
- Disabled: the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Package xbar_pkg:
  - flit_t struct {data, dest}, parameterised through localparams matching the crossbar defaults.
  - State enum {IDLE, SEND}.
- Natural sub-module: xbar_sync_fifo. It is a generic synchronous FIFO with count, full, empty, registered outputs and async active-high reset. The FSM and pending mask stay in xbar_port_sender.

Test Plan (PORTS=4, WIDTH=8, DEPTH=4):
- Unicast: push data 0xA5, dest 0b0100; ack_i tied to xb_dest → xb_dest=0b0100 one cycle after push; retires that cycle; busy then drops to 0.
- Partial multicast: push data 0x3C, dest 0b1011:
  - Cycle 1, ack_i=0b0001 → xb_dest=0b1010 next cycle.
  - Cycle 2, ack_i=0b0000 → no change.
  - Cycle 3, ack_i=0b1010 → retire.
  - xb_data=0x3C throughout.
- Back-to-back: push 0x11/0b0001, 0x22/0b0010, 0x33/0b0100 with full acks → three consecutive SEND cycles with no bubble; data order 0x11, 0x22, 0x33.
- Full FIFO: ack_i=0 with 4 flits pushed → in_ready=0; a 5th in_valid is not accepted; after the head retires, in_ready=1 the following cycle.
- Zero mask and spurious ack:
  - Push 0x77/0b0000 then 0x88/0b0001 → 0x77 is never presented; 0x88 follows.
  - Stray ack_i=0b1110 during 0x88 does not alter pending bits outside 0b0001.
- Reset mid-multicast: assert rst while pending=0b0110 with 2 flits queued → immediate xb_dest=0, busy=0, FIFO empty; after release, in_ready=1 and no stale flit is presented.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and defaults for the multicast crossbar input side.
package xbar_pkg;

  localparam int unsigned XBAR_PORTS = 2;
  localparam int unsigned XBAR_WIDTH = 8;
  localparam int unsigned XBAR_DEPTH = 4;

  typedef struct packed {
    logic [XBAR_WIDTH-1:0] data;
    logic [XBAR_PORTS-1:0] dest;
  } flit_t;

  typedef enum logic {StIdle, StSend} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/xbar_port_sender_if.sv
// Upstream flit handshake plus crossbar-facing request/ack bundle for one input port.
interface xbar_port_sender_if
  import xbar_pkg::*;
#(
  parameter int unsigned PORTS = XBAR_PORTS,
  parameter int unsigned WIDTH = XBAR_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [PORTS-1:0] in_dest;
  logic [WIDTH-1:0] xb_data;
  logic [PORTS-1:0] xb_dest;
  logic [PORTS-1:0] ack_i;
  logic             busy;

  modport master (
    input  in_valid, in_data, in_dest, ack_i,
    output in_ready, xb_data, xb_dest, busy
  );

  modport slave (
    output in_valid, in_data, in_dest, ack_i,
    input  in_ready, xb_data, xb_dest, busy
  );
endinterface

// File: rtl/xbar_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two, at least 2.
module xbar_sync_fifo
  import xbar_pkg::*;
#(
  parameter int unsigned WIDTH = XBAR_WIDTH + XBAR_PORTS,
  parameter int unsigned DEPTH = XBAR_DEPTH,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/xbar_port_sender.sv
// Crossbar input initiator: queues flits, presents the head until every destination acks.
// Optional counters stall_cnt/flit_cnt are built when XBAR_SENDER_STATS_EN is defined.
module xbar_port_sender
  import xbar_pkg::*;
#(
  parameter int unsigned PORTS = XBAR_PORTS,
  parameter int unsigned WIDTH = XBAR_WIDTH,
  parameter int unsigned DEPTH = XBAR_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  xbar_port_sender_if.master  bus
`ifdef XBAR_SENDER_STATS_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flit_cnt
`endif
);

  localparam int unsigned FW = WIDTH + PORTS;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t           state_q, state_d;
  logic [PORTS-1:0] served_q, served_d;
  logic [PORTS-1:0] head_dest, pending, pending_next;
  logic [WIDTH-1:0] head_data;
  logic [FW-1:0]    head_flit;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop, last;

  xbar_sync_fifo #(
    .WIDTH(FW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata({bus.in_data, bus.in_dest}),
    .pop  (pop),
    .rdata(head_flit),
    .count(count),
    .full (full),
    .empty(empty)
  );

  assign head_data = head_flit[FW-1:PORTS];
  assign head_dest = head_flit[PORTS-1:0];

  // Track served outputs rather than the remaining mask so a new head needs no pre-load.
  assign pending      = (state_q == StSend) ? (head_dest & ~served_q) : '0;
  assign pending_next = pending & ~bus.ack_i;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state_q == StSend) && (pending_next == '0);
  assign last         = (count == CW'(1));

  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    unique case (state_q)
      StIdle: begin
        if (!empty || push) state_d = StSend;
      end
      StSend: begin
        if (pop) begin
          served_d = '0;
          if (last && !push) state_d = StIdle;
        end else begin
          served_d = served_q | (bus.ack_i & head_dest);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
    end
  end

  assign bus.in_ready = !full && !rst;
  assign bus.xb_dest  = pending;
  assign bus.busy     = |pending;
  assign bus.xb_data  = (|pending) ? head_data : '0;

`ifdef XBAR_SENDER_STATS_EN
  logic [31:0] stall_q, flit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flit_q  <= '0;
    end else begin
      if (state_q == StSend && !pop) stall_q <= sat_inc(stall_q);
      if (pop) flit_q <= sat_inc(flit_q);
    end
  end

  assign stall_cnt = stall_q;
  assign flit_cnt  = flit_q;
`endif

endmodule

// File: tb/tb_xbar_port_sender.sv
// Directed and random bench for xbar_port_sender against a queue-based delivery model.
module tb_xbar_port_sender;
  localparam int unsigned PORTS = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xbar_port_sender_if #(.PORTS(PORTS), .WIDTH(WIDTH)) bus ();

`ifdef XBAR_SENDER_STATS_EN
  logic [31:0] stall_cnt, flit_cnt;
`endif

  xbar_port_sender #(
    .PORTS(PORTS),
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef XBAR_SENDER_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .flit_cnt (flit_cnt)
`endif
  );

  // Model: queue of flits with the destinations still owed; head is q[0].
  typedef struct {
    logic [WIDTH-1:0] data;
    logic [PORTS-1:0] rem;
  } mflit_t;

  mflit_t      q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flits = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [PORTS-1:0] rem;
    logic [WIDTH-1:0] data;
    rem  = (q.size() > 0) ? q[0].rem : '0;
    data = (rem != '0) ? q[0].data : '0;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!rst && (q.size() < DEPTH)));
    check({tag, ".xb_dest"}, 32'(bus.xb_dest), 32'(rem));
    check({tag, ".xb_data"}, 32'(bus.xb_data), 32'(data));
    check({tag, ".busy"}, 32'(bus.busy), 32'(rem != '0));
`ifdef XBAR_SENDER_STATS_EN
    check({tag, ".stall_cnt"}, stall_cnt, m_stall);
    check({tag, ".flit_cnt"}, flit_cnt, m_flits);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_stall = 0;
    m_flits = 0;
  endtask

  // One clock: drive inputs, update the model at the edge, return 1 time unit after it.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [PORTS-1:0] dst,
                      input logic [PORTS-1:0] ack);
    logic             acc;
    logic [PORTS-1:0] r;
    mflit_t           f;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_dest  = dst;
    bus.ack_i    = ack;
    acc = v && !rst && (q.size() < DEPTH);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (q.size() > 0) begin
        r = q[0].rem & ~ack;
        if (r == '0) begin
          void'(q.pop_front());
          m_flits++;
        end else begin
          q[0].rem = r;
          m_stall++;
        end
      end
      if (acc) begin
        f.data = d;
        f.rem  = dst;
        q.push_back(f);
      end
    end
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && q.size() > 0; i++) begin
      step(1'b0, '0, '0, '1);
      check_all(tag);
    end
    check({tag, ".empty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dest  = '0;
    bus.ack_i    = '0;
    #2;
    check_all("rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(bus.in_ready), 32'd1);
    check_all("rel");
    @(posedge clk);
    #1;

    // Unicast
    step(1'b1, 8'hA5, 4'b0100, 4'b0000);
    check_all("uni_push");
    check("uni_dest", 32'(bus.xb_dest), 32'h4);
    step(1'b0, '0, '0, 4'b0100);
    check_all("uni_ret");
    check("uni_busy", 32'(bus.busy), 32'd0);

    // Partial multicast
    step(1'b1, 8'h3C, 4'b1011, 4'b0000);
    check_all("mc0");
    check("mc0_dest", 32'(bus.xb_dest), 32'hB);
    step(1'b0, '0, '0, 4'b0001);
    check_all("mc1");
    check("mc1_dest", 32'(bus.xb_dest), 32'hA);
    check("mc1_data", 32'(bus.xb_data), 32'h3C);
    step(1'b0, '0, '0, 4'b0000);
    check_all("mc2");
    check("mc2_dest", 32'(bus.xb_dest), 32'hA);
    step(1'b0, '0, '0, 4'b1010);
    check_all("mc3");
    check("mc3_busy", 32'(bus.busy), 32'd0);

    // Back-to-back with full acks
    step(1'b1, 8'h11, 4'b0001, 4'b1111);
    check("b2b_d0", 32'(bus.xb_data), 32'h11);
    check_all("b2b0");
    step(1'b1, 8'h22, 4'b0010, 4'b1111);
    check("b2b_d1", 32'(bus.xb_data), 32'h22);
    check_all("b2b1");
    step(1'b1, 8'h33, 4'b0100, 4'b1111);
    check("b2b_d2", 32'(bus.xb_data), 32'h33);
    check_all("b2b2");
    step(1'b0, '0, '0, 4'b1111);
    check_all("b2b_end");

    // Full FIFO
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h40 + i), 4'b0011, 4'b0000);
      check_all("fill");
    end
    check("full_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, 8'h99, 4'b0001, 4'b0000);
    check_all("full_rej");
    check("full_rej_ready", 32'(bus.in_ready), 32'd0);
    step(1'b0, '0, '0, 4'b0011);
    check_all("full_pop");
    check("full_pop_ready", 32'(bus.in_ready), 32'd1);
    drain("full_drain");

    // Zero mask and spurious ack
    step(1'b1, 8'h77, 4'b0000, 4'b0000);
    check_all("zm0");
    check("zm0_busy", 32'(bus.busy), 32'd0);
    step(1'b1, 8'h88, 4'b0001, 4'b0000);
    check_all("zm1");
    check("zm1_data", 32'(bus.xb_data), 32'h88);
    step(1'b0, '0, '0, 4'b1110);
    check_all("zm_stray");
    check("zm_stray_dest", 32'(bus.xb_dest), 32'h1);
    step(1'b0, '0, '0, 4'b0001);
    check_all("zm_ret");

    // Reset mid-multicast
    step(1'b1, 8'h5A, 4'b0110, 4'b0000);
    step(1'b1, 8'h6B, 4'b0011, 4'b0000);
    check_all("mr_pre");
    check("mr_pre_dest", 32'(bus.xb_dest), 32'h6);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("mr_async");
    check("mr_async_dest", 32'(bus.xb_dest), 32'h0);
    @(posedge clk);
    #1;
    check_all("mr_hold");
    rst = 1'b0;
    #1;
    check("mr_rel_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 4'b1111);
      check_all("mr_after");
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [PORTS-1:0] ack;
      ack = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
      step(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), ack);
      check_all("rnd");
    end
    drain("rnd_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
